// File: rtl/exc_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// exc_ctrl_pkg
// Shared definitions for the exception controller and its priority encoder:
// FSM state encoding, cause field layout and default handler vectors.
// -----------------------------------------------------------------------------
package exc_ctrl_pkg;

   // Controller state: USER runs normal code, HANDLER runs an exception handler.
   typedef enum logic [0:0] {
      ST_USER    = 1'b0,
      ST_HANDLER = 1'b1
   } excState_t;

   // Cause field: bit 4 flags an overflow, bits 3:0 carry the serviced IRQ index.
   localparam int CAUSE_W       = 5;
   localparam int IDX_W         = 4;

   localparam logic [31:0]        DEF_IRQ_VEC = 32'h8000_0004;
   localparam logic [31:0]        DEF_EXC_VEC = 32'h8000_0008;
   localparam logic [CAUSE_W-1:0] CAUSE_RST   = 5'h00;

   // Build a cause word from the overflow flag and an IRQ index.
   function automatic logic [CAUSE_W-1:0] packCause(input logic isOvf,
                                                    input logic [IDX_W-1:0] idx);
      packCause = {isOvf, idx};
   endfunction

endpackage

// File: rtl/exc_ctrl_irq_prio_enc.sv
// -----------------------------------------------------------------------------
// irq_prio_enc
// Lowest-index-wins priority encoder.
// Ports:
//   iReq   [N]     request vector
//   oIdx   [IDX_W] index of the lowest set request (0 when none)
//   oValid         1 when any request is set
// -----------------------------------------------------------------------------
module irq_prio_enc
   import exc_ctrl_pkg::*;
#(
   parameter int N = 4
) (
   input  logic [N-1:0]     iReq,
   output logic [IDX_W-1:0] oIdx,
   output logic             oValid
);

   // Scan from the top down so the lowest set index is the last one written.
   always_comb begin
      oIdx   = {IDX_W{1'b0}};
      oValid = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         oIdx   = iReq[i] ? IDX_W'(i) : oIdx;
         oValid = oValid | iReq[i];
      end
   end

endmodule

// File: rtl/exc_ctrl.sv
// -----------------------------------------------------------------------------
// exc_ctrl
// Exception/interrupt controller for a single-issue core. Detects rising edges
// on the IRQ lines, keeps them pending, and redirects the core either to the
// overflow handler or the interrupt handler. One level of handler, no nesting.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   iIrq[NUM_IRQ]       level IRQ lines (edge detected internally)
//   iOverflow           ALU overflow of the executing instruction
//   iPC, iPCNext        current / sequential-next instruction address
//   iEret               handler-return instruction
//   iMaskWe, iMaskData  mask register write (1 = channel enabled)
//   oTake, oVector      redirect strobe and target (combinational)
//   oEPC, oCause        saved resume address and cause
//   oKernel             1 while in the handler
//   oDoubleFault        sticky: overflow raised inside the handler
// -----------------------------------------------------------------------------
module exc_ctrl
   import exc_ctrl_pkg::*;
#(
   parameter int                 NUM_IRQ  = 4,
   parameter logic [31:0]        IRQ_VEC  = DEF_IRQ_VEC,
   parameter logic [31:0]        EXC_VEC  = DEF_EXC_VEC,
   parameter logic [NUM_IRQ-1:0] MASK_RST = {NUM_IRQ{1'b1}}
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [NUM_IRQ-1:0] iIrq,
   input  logic               iOverflow,
   input  logic [31:0]        iPC,
   input  logic [31:0]        iPCNext,
   input  logic               iEret,
   input  logic               iMaskWe,
   input  logic [NUM_IRQ-1:0] iMaskData,
   output logic               oTake,
   output logic [31:0]        oVector,
   output logic [31:0]        oEPC,
   output logic [CAUSE_W-1:0] oCause,
   output logic               oKernel,
   output logic               oDoubleFault
);

   excState_t            state_r, stateNext_s;
   logic [NUM_IRQ-1:0]   irqPrev_r, pending_r, mask_r;
   logic [NUM_IRQ-1:0]   rise_s, eligible_s, clear_s, pendingNext_s;
   logic [31:0]          epc_r, epcNext_s;
   logic [CAUSE_W-1:0]   cause_r, causeNext_s;
   logic                 dblFault_r, dblFaultNext_s;
   logic [IDX_W-1:0]     winIdx_s;
   logic                 winValid_s;
   logic                 take_s, takeIrq_s;
   logic [31:0]          vector_s;

   assign rise_s     = iIrq & ~irqPrev_r;
   assign eligible_s = pending_r & mask_r;

   irq_prio_enc #(.N(NUM_IRQ)) uPrioEnc (
      .iReq   (eligible_s),
      .oIdx   (winIdx_s),
      .oValid (winValid_s)
   );

   // An IRQ is only serviced when overflow does not pre-empt it.
   assign takeIrq_s = (state_r == ST_USER) & ~iOverflow & winValid_s;

   // One-hot clear of the winning pending bit; a same-cycle new edge still sets it.
   always_comb begin
      clear_s = {NUM_IRQ{1'b0}};
      for (int i = 0; i < NUM_IRQ; i++) begin
         clear_s[i] = takeIrq_s & (winIdx_s == IDX_W'(i));
      end
      pendingNext_s = (pending_r & ~clear_s) | rise_s;
   end

   // FSM next-state, redirect decision and handler-entry bookkeeping.
   always_comb begin
      stateNext_s    = state_r;
      epcNext_s      = epc_r;
      causeNext_s    = cause_r;
      dblFaultNext_s = dblFault_r;
      take_s         = 1'b0;
      vector_s       = IRQ_VEC;
      case (state_r)
         ST_USER: begin
            take_s   = iOverflow | winValid_s;
            vector_s = iOverflow ? EXC_VEC : IRQ_VEC;
            if (iOverflow) begin
               stateNext_s = ST_HANDLER;
               epcNext_s   = iPC;
               causeNext_s = packCause(1'b1, 4'h0);
            end else if (winValid_s) begin
               stateNext_s = ST_HANDLER;
               epcNext_s   = iPCNext;
               causeNext_s = packCause(1'b0, winIdx_s);
            end else begin
               stateNext_s = ST_USER;
            end
         end
         ST_HANDLER: begin
            if (iOverflow) begin
               dblFaultNext_s = 1'b1;
            end else begin
               dblFaultNext_s = dblFault_r;
            end
            if (iEret) begin
               stateNext_s = ST_USER;
            end else begin
               stateNext_s = ST_HANDLER;
            end
         end
         default: begin
            stateNext_s = ST_USER;
         end
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_USER;
      end else begin
         state_r <= stateNext_s;
      end
   end

   // Edge history, pending, mask and saved-context registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         irqPrev_r  <= {NUM_IRQ{1'b0}};
         pending_r  <= {NUM_IRQ{1'b0}};
         mask_r     <= MASK_RST;
         epc_r      <= 32'h0000_0000;
         cause_r    <= CAUSE_RST;
         dblFault_r <= 1'b0;
      end else begin
         irqPrev_r  <= iIrq;
         pending_r  <= pendingNext_s;
         mask_r     <= iMaskWe ? iMaskData : mask_r;
         epc_r      <= epcNext_s;
         cause_r    <= causeNext_s;
         dblFault_r <= dblFaultNext_s;
      end
   end

   // The redirect must never fire while the core is held in reset.
   assign oTake        = take_s & reset;
   assign oVector      = vector_s;
   assign oEPC         = epc_r;
   assign oCause       = cause_r;
   assign oKernel      = (state_r == ST_HANDLER);
   assign oDoubleFault = dblFault_r;

endmodule
